// File: rtl/trail_manager_pkg.sv
// Shared types for the assignment trail: trail entry layout, FSM states and counter widths.
package trail_manager_pkg;

  localparam int TRAIL_LVL_W = 16;
  localparam int TRAIL_VAR_W = 32;

  typedef struct packed {
    logic [TRAIL_VAR_W-1:0] vidx;
    logic                   value;
    logic                   is_decision;
  } trail_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    DONE = 2'd2
  } trail_state_e;

endpackage

// File: rtl/trail_manager_ram.sv
// Trail storage: one write port at the push slot, one combinational read port at the top entry.
module trail_manager_ram
  import trail_manager_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  trail_entry_t           wdata,
  input  logic [AW-1:0]          raddr,
  output logic [TRAIL_VAR_W-1:0] rd_var,
  output logic                   rd_dec
);

  trail_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rd_var = mem_q[raddr].vidx;
  assign rd_dec = mem_q[raddr].is_decision;

endmodule

// File: rtl/trail_manager.sv
// Assignment trail for one solver core: records decisions/implications, echoes them to vde,
// and on backtrack pops one entry per cycle, emitting a clear for each popped variable.
module trail_manager
  import trail_manager_pkg::*;
#(
  parameter int MAX_VARS   = 16,
  parameter int MAX_LEVELS = 16,
  parameter int VAR_W      = TRAIL_VAR_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear_all,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [VAR_W-1:0]       push_var,
  input  logic                   push_value,
  input  logic                   push_is_decision,
  input  logic                   backtrack_valid,
  input  logic [TRAIL_LVL_W-1:0] backtrack_level,
  output logic                   backtrack_done,
  output logic                   busy,
  output logic                   assign_valid,
  output logic [VAR_W-1:0]       assign_var,
  output logic                   assign_value,
  output logic                   clear_valid,
  output logic [VAR_W-1:0]       clear_var,
  output logic [TRAIL_LVL_W-1:0] current_level,
  output logic [TRAIL_LVL_W-1:0] trail_count,
  output logic                   full,
  output logic                   overflow
);

  localparam int AW  = $clog2(MAX_VARS);
  localparam int LPW = $clog2(MAX_LEVELS + 1);
  localparam logic [TRAIL_LVL_W-1:0] MAX_VARS_C   = TRAIL_LVL_W'(MAX_VARS);
  localparam logic [TRAIL_LVL_W-1:0] MAX_LEVELS_C = TRAIL_LVL_W'(MAX_LEVELS);

  trail_state_e           state_q, state_d;
  logic [TRAIL_LVL_W-1:0] count_q, count_d;
  logic [TRAIL_LVL_W-1:0] level_q, level_d;
  logic [TRAIL_LVL_W-1:0] target_q, target_d;
  logic [TRAIL_LVL_W-1:0] bt_lvl_q, bt_lvl_d;
  logic [TRAIL_LVL_W-1:0] level_ptr_q [MAX_LEVELS+1];
  logic [TRAIL_LVL_W-1:0] level_ptr_d [MAX_LEVELS+1];
  logic                   overflow_q, overflow_d;
  logic                   assign_valid_q, assign_valid_d;
  logic [VAR_W-1:0]       assign_var_q, assign_var_d;
  logic                   assign_value_q, assign_value_d;

  logic                   ram_we;
  trail_entry_t           ram_wdata;
  logic [TRAIL_VAR_W-1:0] top_var;
  logic                   top_dec;
  logic                   push_attempt, push_bad, push_accept;
  logic                   var_ok, lvl_ok;
  logic [LPW-1:0]         bt_idx, dec_idx;

  assign full    = (count_q == MAX_VARS_C);
  assign var_ok  = (push_var != '0) && (push_var <= VAR_W'(MAX_VARS));
  assign lvl_ok  = !push_is_decision || (level_q != MAX_LEVELS_C);
  assign bt_idx  = LPW'(backtrack_level + 16'd1);
  assign dec_idx = LPW'(level_q + 16'd1);

  // A push is only considered when nothing with higher priority claims the cycle.
  assign push_attempt = push_valid && (state_q == IDLE) && !backtrack_valid && !clear_all;
  assign push_bad     = push_attempt && (full || !var_ok || !lvl_ok);
  assign push_accept  = push_attempt && !push_bad;

  assign push_ready     = reset_n && (state_q == IDLE) && !full && !backtrack_valid && !clear_all;
  assign busy           = (state_q == POP);
  assign clear_valid    = (state_q == POP) && !clear_all;
  assign clear_var      = clear_valid ? VAR_W'(top_var) : '0;
  assign backtrack_done = (state_q == DONE) && !clear_all;
  assign assign_valid   = assign_valid_q;
  assign assign_var     = assign_var_q;
  assign assign_value   = assign_value_q;
  assign current_level  = level_q;
  assign trail_count    = count_q;
  assign overflow       = overflow_q;

  assign ram_wdata = '{vidx: TRAIL_VAR_W'(push_var), value: push_value, is_decision: push_is_decision};

  trail_manager_ram #(.DEPTH(MAX_VARS), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (count_q[AW-1:0]),
    .wdata (ram_wdata),
    .raddr (AW'(count_q - 16'd1)),
    .rd_var(top_var),
    .rd_dec(top_dec)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    level_d        = level_q;
    target_d       = target_q;
    bt_lvl_d       = bt_lvl_q;
    level_ptr_d    = level_ptr_q;
    overflow_d     = overflow_q;
    assign_valid_d = 1'b0;
    assign_var_d   = assign_var_q;
    assign_value_d = assign_value_q;
    ram_we         = push_accept;

    if (clear_all) begin
      state_d    = IDLE;
      count_d    = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          overflow_d = overflow_q | push_bad;
          if (backtrack_valid) begin
            if (backtrack_level < level_q) begin
              target_d = level_ptr_q[bt_idx];
              bt_lvl_d = backtrack_level;
              state_d  = POP;
            end else begin
              state_d = DONE;
            end
          end else if (push_accept) begin
            count_d        = count_q + 16'd1;
            assign_valid_d = 1'b1;
            assign_var_d   = push_var;
            assign_value_d = push_value;
            if (push_is_decision) begin
              level_d              = level_q + 16'd1;
              level_ptr_d[dec_idx] = count_q;
            end
          end
        end
        POP: begin
          count_d = count_q - 16'd1;
          level_d = level_q - {15'd0, top_dec};
          if ((count_q - 16'd1) == target_q) begin
            level_d = bt_lvl_q;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      level_q        <= '0;
      target_q       <= '0;
      bt_lvl_q       <= '0;
      overflow_q     <= 1'b0;
      assign_valid_q <= 1'b0;
      assign_var_q   <= '0;
      assign_value_q <= 1'b0;
      for (int i = 0; i <= MAX_LEVELS; i++) level_ptr_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      level_q        <= level_d;
      target_q       <= target_d;
      bt_lvl_q       <= bt_lvl_d;
      overflow_q     <= overflow_d;
      assign_valid_q <= assign_valid_d;
      assign_var_q   <= assign_var_d;
      assign_value_q <= assign_value_d;
      level_ptr_q    <= level_ptr_d;
    end
  end

endmodule

// File: tb/tb_trail_manager.sv
// Self-checking bench for trail_manager: directed scenarios plus randomized push/backtrack
// rounds checked against a queue-based model of the trail.
module tb_trail_manager;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear_all = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_var = '0;
  logic        push_value = 1'b0;
  logic        push_is_decision = 1'b0;
  logic        backtrack_valid = 1'b0;
  logic [15:0] backtrack_level = '0;
  logic        backtrack_done, busy;
  logic        assign_valid, assign_value, clear_valid, full, overflow;
  logic [31:0] assign_var, clear_var;
  logic [15:0] current_level, trail_count;

  trail_manager dut (
    .clk(clk), .reset_n(reset_n), .clear_all(clear_all),
    .push_valid(push_valid), .push_ready(push_ready), .push_var(push_var),
    .push_value(push_value), .push_is_decision(push_is_decision),
    .backtrack_valid(backtrack_valid), .backtrack_level(backtrack_level),
    .backtrack_done(backtrack_done), .busy(busy),
    .assign_valid(assign_valid), .assign_var(assign_var), .assign_value(assign_value),
    .clear_valid(clear_valid), .clear_var(clear_var),
    .current_level(current_level), .trail_count(trail_count),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the trail is an ordered list; level = number of decisions on it.
  typedef struct { int v; bit val; bit dec; } ent_t;
  ent_t mq[$];
  bit   m_ovf = 1'b0;
  int   exp_clr[$];
  int   got_clr[$];
  int   got_clr_cyc[$];
  int   got_done_cyc;
  bit   got_busy1;

  function automatic int m_level();
    int n = 0;
    foreach (mq[i]) if (mq[i].dec) n++;
    return n;
  endfunction

  function automatic bit m_push(int v, bit val, bit dec);
    if (mq.size() >= 16 || v < 1 || v > 16 || (dec && m_level() == 16)) begin
      m_ovf = 1'b1;
      return 1'b0;
    end
    mq.push_back('{v: v, val: val, dec: dec});
    return 1'b1;
  endfunction

  function automatic void m_backtrack(int lvl);
    ent_t e;
    exp_clr.delete();
    while (m_level() > lvl) begin
      e = mq.pop_back();
      exp_clr.push_back(e.v);
    end
  endfunction

  function automatic bit m_on_trail(int v);
    foreach (mq[i]) if (mq[i].v == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_cycle(input int v, input bit val, input bit dec,
                            output bit rdy, output bit av, output int avar, output bit aval);
    @(posedge clk); #1;
    push_valid = 1'b1; push_var = v; push_value = val; push_is_decision = dec;
    @(negedge clk);
    rdy = push_ready;
    @(posedge clk); #1;
    push_valid = 1'b0;
    @(negedge clk);
    av = assign_valid; avar = assign_var; aval = assign_value;
  endtask

  task automatic bt_cycle(input int lvl);
    got_clr.delete(); got_clr_cyc.delete();
    got_done_cyc = -1; got_busy1 = 1'b0;
    @(posedge clk); #1;
    backtrack_valid = 1'b1; backtrack_level = lvl[15:0];
    @(posedge clk); #1;
    backtrack_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (c == 1) got_busy1 = busy;
      if (clear_valid) begin got_clr.push_back(int'(clear_var)); got_clr_cyc.push_back(c); end
      if (backtrack_done) begin got_done_cyc = c; break; end
    end
  endtask

  task automatic pulse_clear_all();
    @(posedge clk); #1; clear_all = 1'b1;
    @(posedge clk); #1; clear_all = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    @(negedge clk);
    n_cmp++;
    if ({push_ready, backtrack_done, busy, assign_valid, assign_var, assign_value, clear_valid,
         clear_var, current_level, trail_count, full, overflow} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during reset (count=%0d level=%0d rdy=%0b)",
                         trail_count, current_level, push_ready);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", push_ready); end
  endtask

  task automatic test_directed_pushes();
    int vs[3] = '{3, 7, 5};
    bit vl[3] = '{1, 0, 1};
    bit dc[3] = '{1, 0, 1};
    bit rdy, av, aval, acc;
    int avar;
    for (int i = 0; i < 3; i++) begin
      push_cycle(vs[i], vl[i], dc[i], rdy, av, avar, aval);
      acc = m_push(vs[i], vl[i], dc[i]);
      n_cmp++;
      if ({rdy, av, aval} !== {1'b1, acc, vl[i]} || avar != vs[i]) begin
        n_fail++; $display("FAIL push_echo[%0d]: rdy=%0b av=%0b var=%0d val=%0b want 1 1 %0d %0b",
                           i, rdy, av, avar, aval, vs[i], vl[i]);
      end
    end
    n_cmp++;
    if (trail_count !== 16'(mq.size()) || current_level !== 16'd2) begin
      n_fail++; $display("FAIL push_state: count=%0d level=%0d want %0d 2", trail_count, current_level, mq.size());
    end
  endtask

  task automatic check_backtrack(input string nm, input int lvl);
    int base;
    base = m_level();
    m_backtrack(lvl);
    bt_cycle(lvl);
    n_cmp++;
    if (got_clr.size() != exp_clr.size()) begin
      n_fail++; $display("FAIL %s_nclears: got %0d want %0d", nm, got_clr.size(), exp_clr.size());
    end else begin
      foreach (exp_clr[i]) begin
        n_cmp++;
        if (got_clr[i] != exp_clr[i] || got_clr_cyc[i] != i + 1) begin
          n_fail++; $display("FAIL %s_clear[%0d]: var=%0d cyc=%0d want var=%0d cyc=%0d",
                             nm, i, got_clr[i], got_clr_cyc[i], exp_clr[i], i + 1);
        end
      end
    end
    n_cmp++;
    if (got_done_cyc != exp_clr.size() + 1) begin
      n_fail++; $display("FAIL %s_done: cycle %0d want %0d", nm, got_done_cyc, exp_clr.size() + 1);
    end
    n_cmp++;
    if (got_busy1 !== (lvl < base)) begin
      n_fail++; $display("FAIL %s_busy: got %0b want %0b", nm, got_busy1, lvl < base);
    end
    @(negedge clk);
    n_cmp++;
    if (trail_count !== 16'(mq.size()) || current_level !== 16'(m_level()) || clear_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_after: count=%0d level=%0d clr=%0b want %0d %0d 0",
                         nm, trail_count, current_level, clear_valid, mq.size(), m_level());
    end
  endtask

  task automatic test_backtrack_one();
    check_backtrack("bt1", 1);
  endtask

  task automatic test_back_to_back();
    bit rdy, av, aval, acc;
    int avar;
    int vs[3] = '{1, 2, 4};
    for (int i = 0; i < 3; i++) begin
      push_cycle(vs[i], 1'b0, 1'b1, rdy, av, avar, aval);
      acc = m_push(vs[i], 1'b0, 1'b1);
      n_cmp++;
      if (av !== acc || avar != vs[i]) begin
        n_fail++; $display("FAIL b2b_push[%0d]: av=%0b var=%0d want %0b %0d", i, av, avar, acc, vs[i]);
      end
    end
    n_cmp++;
    if (current_level !== 16'd4) begin n_fail++; $display("FAIL b2b_level: got %0d want 4", current_level); end
    check_backtrack("b2b", 0);
  endtask

  task automatic test_full_overflow();
    bit rdy, av, aval, acc;
    int avar;
    for (int v = 1; v <= 16; v++) begin
      bit d;
      d = 1'($urandom_range(0, 1));
      push_cycle(v, 1'b1, d, rdy, av, avar, aval);
      acc = m_push(v, 1'b1, d);
      n_cmp++;
      if (av !== acc) begin n_fail++; $display("FAIL fill_push[%0d]: av=%0b want %0b", v, av, acc); end
    end
    n_cmp++;
    if (full !== 1'b1 || push_ready !== 1'b0 || trail_count !== 16'd16 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_flags: full=%0b rdy=%0b count=%0d ovf=%0b want 1 0 16 0",
                         full, push_ready, trail_count, overflow);
    end
    push_cycle(5, 1'b0, 1'b0, rdy, av, avar, aval);
    acc = m_push(5, 1'b0, 1'b0);
    n_cmp++;
    if (rdy !== 1'b0 || av !== acc || overflow !== m_ovf || trail_count !== 16'd16) begin
      n_fail++; $display("FAIL overflow_17th: rdy=%0b av=%0b ovf=%0b count=%0d want 0 0 1 16",
                         rdy, av, overflow, trail_count);
    end
    pulse_clear_all();
    n_cmp++;
    if (trail_count !== 16'd0 || current_level !== 16'd0 || overflow !== 1'b0 || full !== 1'b0) begin
      n_fail++; $display("FAIL clear_all_flush: count=%0d level=%0d ovf=%0b full=%0b want 0 0 0 0",
                         trail_count, current_level, overflow, full);
    end
  endtask

  task automatic test_bad_var();
    bit rdy, av, aval, acc;
    int avar;
    int bad[2] = '{0, 17};
    for (int i = 0; i < 2; i++) begin
      push_cycle(bad[i], 1'b1, 1'b0, rdy, av, avar, aval);
      acc = m_push(bad[i], 1'b1, 1'b0);
      n_cmp++;
      if (av !== acc || overflow !== m_ovf || trail_count !== 16'(mq.size())) begin
        n_fail++; $display("FAIL bad_var[%0d]: av=%0b ovf=%0b count=%0d want 0 1 %0d",
                           bad[i], av, overflow, trail_count, mq.size());
      end
    end
    pulse_clear_all();
  endtask

  task automatic test_bt_noop();
    bit rdy, av, aval, acc;
    int avar;
    push_cycle(3, 1'b1, 1'b1, rdy, av, avar, aval); acc = m_push(3, 1'b1, 1'b1);
    push_cycle(9, 1'b0, 1'b1, rdy, av, avar, aval); acc = m_push(9, 1'b0, 1'b1);
    check_backtrack("noop", 3);
    pulse_clear_all();
  endtask

  task automatic test_random();
    bit rdy, av, aval, acc;
    int avar, v, n, lvl;
    bit d, val;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n && mq.size() < 16; k++) begin
        do v = $urandom_range(1, 16); while (m_on_trail(v));
        d = 1'($urandom_range(0, 1)); val = 1'($urandom_range(0, 1));
        push_cycle(v, val, d, rdy, av, avar, aval);
        acc = m_push(v, val, d);
        n_cmp++;
        if (av !== acc || (acc && (avar != v || aval !== val))) begin
          n_fail++; $display("FAIL rnd_push[%0d.%0d]: av=%0b var=%0d val=%0b want %0b %0d %0b",
                             r, k, av, avar, aval, acc, v, val);
        end
      end
      lvl = $urandom_range(0, m_level() + 1);
      check_backtrack("rnd", lvl);
    end
    pulse_clear_all();
  endtask

  task automatic build_trail(input int n);
    bit rdy, av, aval, acc;
    int avar;
    for (int v = 1; v <= n; v++) begin
      push_cycle(v, 1'b0, 1'b1, rdy, av, avar, aval);
      acc = m_push(v, 1'b0, 1'b1);
    end
  endtask

  task automatic test_abort_mid_pop();
    int extra;
    // clear_all after two clears
    build_trail(5);
    @(posedge clk); #1; backtrack_valid = 1'b1; backtrack_level = 16'd0;
    @(posedge clk); #1; backtrack_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (clear_valid !== 1'b1 || clear_var !== 32'd4) begin
      n_fail++; $display("FAIL abort_prep: clr=%0b var=%0d want 1 4", clear_valid, clear_var);
    end
    @(posedge clk); #1; clear_all = 1'b1;
    @(negedge clk);
    extra = clear_valid + backtrack_done;
    @(posedge clk); #1; clear_all = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      extra += clear_valid + backtrack_done;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (extra != 0 || trail_count !== 16'd0 || current_level !== 16'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clear_all_mid_pop: stray=%0d count=%0d level=%0d busy=%0b want 0 0 0 0",
                         extra, trail_count, current_level, busy);
    end
    // asynchronous reset after two clears
    build_trail(4);
    @(posedge clk); #1; backtrack_valid = 1'b1; backtrack_level = 16'd0;
    @(posedge clk); #1; backtrack_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3; reset_n = 1'b0;
    #1;
    n_cmp++;
    if (clear_valid !== 1'b0 || busy !== 1'b0 || trail_count !== 16'd0 || current_level !== 16'd0) begin
      n_fail++; $display("FAIL reset_mid_pop: clr=%0b busy=%0b count=%0d level=%0d want 0 0 0 0",
                         clear_valid, busy, trail_count, current_level);
    end
    mq.delete(); m_ovf = 1'b0;
    @(posedge clk); #1; reset_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      extra += clear_valid + backtrack_done;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (extra != 0 || push_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_recover: stray=%0d rdy=%0b want 0 1", extra, push_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed_pushes();
    test_backtrack_one();
    test_back_to_back();
    test_full_overflow();
    test_bad_var();
    test_bt_noop();
    test_random();
    test_abort_mid_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
